matrix_uart_tx_formatter: RTL and testbench

Transmit-side counterpart of the UART matrix input parser. On a start pulse it reads an m x n matrix of 32-bit elements from Matrix_storage in row-major order. Each element is converted to signed decimal ASCII, and the rows are sent over an 8N1 UART line. It sits beside the display path and drives the storage read port while busy; the storage mux grants it the port whenever o_busy is high.

---
 rtl/matrix_uart_tx_formatter_pkg.sv | 32 +++
 rtl/matrix_uart_tx_formatter_uart_byte_tx.sv | 57 +++++
 rtl/matrix_uart_tx_formatter.sv | 190 +++++++++++++++++++
 tb/tb_matrix_uart_tx_formatter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_uart_tx_formatter_pkg.sv
// Shared constants for the matrix UART transmit formatter: ASCII codes,
// FSM state encoding and the decimal conversion table.
package matrix_uart_tx_formatter_pkg;

    localparam logic [7:0] CHAR_MINUS = 8'h2D;
    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_ZERO  = 8'h30;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ERR,
        S_FETCH,
        S_WAIT_RD,
        S_CONV,
        S_SEND_SIGN,
        S_SEND_DIG,
        S_SEND_SEP,
        S_SEND_CR,
        S_SEND_LF,
        S_DRAIN,
        S_DONE
    } state_t;

    // Index 0 is the most significant place, so digits come out MSD first.
    localparam logic [31:0] POW10 [10] = '{
        32'd1000000000, 32'd100000000, 32'd10000000, 32'd1000000, 32'd100000,
        32'd10000,      32'd1000,      32'd100,      32'd10,      32'd1
    };

endpackage

// File: rtl/matrix_uart_tx_formatter_uart_byte_tx.sv
// 8N1 UART byte transmitter: start bit, 8 data bits LSB first, stop bit,
// each held for CLKS_PER_BIT clocks. tx_busy covers the whole frame.
module uart_byte_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_pin
);

    localparam int            CW       = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit;
    logic [8:0]    r_shift;
    logic          r_busy;
    logic          r_pin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '1;
            r_busy  <= 1'b0;
            r_pin   <= 1'b1;
        end else if (!r_busy) begin
            if (tx_start) begin
                r_busy  <= 1'b1;
                r_pin   <= 1'b0;
                r_shift <= {1'b1, tx_data};
                r_cnt   <= '0;
                r_bit   <= '0;
            end
        end else if (r_cnt != CNT_LAST) begin
            r_cnt <= r_cnt + CW'(1);
        end else begin
            r_cnt <= '0;
            if (r_bit == 4'd9) begin
                r_busy <= 1'b0;
                r_pin  <= 1'b1;
            end else begin
                // The stop bit rides in at the top of the shifter behind the data.
                r_pin   <= r_shift[0];
                r_shift <= {1'b1, r_shift[8:1]};
                r_bit   <= r_bit + 4'd1;
            end
        end
    end

    assign tx_busy = r_busy;
    assign tx_pin  = r_pin;

endmodule

// File: rtl/matrix_uart_tx_formatter.sv
// Reads an m x n matrix from storage row-major, converts each element to
// decimal ASCII and streams the rows out over an 8N1 UART line.
module matrix_uart_tx_formatter
    import matrix_uart_tx_formatter_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int MAX_DIM   = 5,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_base_addr,
    input  logic [2:0]  i_m,
    input  logic [2:0]  i_n,
    output logic [7:0]  o_rd_addr,
    input  logic [31:0] i_rd_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic        uart_tx_pin
);

    localparam int         CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [2:0] MAX_DIM_W    = 3'(MAX_DIM);

    state_t      r_state, w_next;
    logic [7:0]  r_rd_addr;
    logic [2:0]  r_m, r_n, r_r, r_c;
    logic [31:0] r_mag;
    logic        r_neg;
    logic [3:0]  r_pidx, r_dcur, r_ndig, r_didx;
    logic [3:0]  r_digits [10];

    logic        w_tx_start, w_tx_busy, w_tx_free;
    logic [7:0]  w_tx_data;
    logic        w_dims_bad, w_last_col, w_last_row, w_ge, w_last_pow, w_rd_neg;

    assign w_dims_bad = (i_m == 3'd0) || (i_n == 3'd0) || (i_m > MAX_DIM_W) || (i_n > MAX_DIM_W);
    assign w_last_col = (r_c == r_n - 3'd1);
    assign w_last_row = (r_r == r_m - 3'd1);
    assign w_ge       = (r_mag >= POW10[r_pidx]);
    assign w_last_pow = (r_pidx == 4'd9);
    assign w_rd_neg   = SIGNED_EN && i_rd_data[31];
    assign w_tx_free  = !w_tx_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        w_next     = r_state;
        w_tx_start = 1'b0;
        w_tx_data  = CHAR_SPACE;
        case (r_state)
            S_IDLE:    if (i_start) w_next = w_dims_bad ? S_ERR : S_FETCH;
            S_ERR:     w_next = S_IDLE;
            S_FETCH:   w_next = S_WAIT_RD;
            S_WAIT_RD: w_next = S_CONV;
            S_CONV:    if (!w_ge && w_last_pow) w_next = S_SEND_SIGN;
            S_SEND_SIGN: begin
                w_tx_data = CHAR_MINUS;
                if (!r_neg) begin
                    w_next = S_SEND_DIG;
                end else if (w_tx_free) begin
                    w_tx_start = 1'b1;
                    w_next     = S_SEND_DIG;
                end
            end
            S_SEND_DIG: begin
                w_tx_data = CHAR_ZERO | {4'd0, r_digits[r_didx]};
                if (w_tx_free) begin
                    w_tx_start = 1'b1;
                    if (r_didx == r_ndig - 4'd1) w_next = S_SEND_SEP;
                end
            end
            S_SEND_SEP: begin
                if (w_last_col) begin
                    w_next = S_SEND_CR;
                end else if (w_tx_free) begin
                    w_tx_start = 1'b1;
                    w_next     = S_FETCH;
                end
            end
            S_SEND_CR: begin
                w_tx_data = CHAR_CR;
                if (w_tx_free) begin
                    w_tx_start = 1'b1;
                    w_next     = S_SEND_LF;
                end
            end
            S_SEND_LF: begin
                w_tx_data = CHAR_LF;
                if (w_tx_free) begin
                    w_tx_start = 1'b1;
                    w_next     = w_last_row ? S_DRAIN : S_FETCH;
                end
            end
            S_DRAIN:   if (w_tx_free) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Elements are contiguous row-major, so base + r*n + c is a running pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_addr <= '0;
            r_m       <= '0;
            r_n       <= '0;
            r_r       <= '0;
            r_c       <= '0;
            r_mag     <= '0;
            r_neg     <= 1'b0;
            r_pidx    <= '0;
            r_dcur    <= '0;
            r_ndig    <= '0;
            r_didx    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_m <= i_m;
                    r_n <= i_n;
                    if (!w_dims_bad) begin
                        r_rd_addr <= i_base_addr;
                        r_r       <= '0;
                        r_c       <= '0;
                    end
                end
                S_WAIT_RD: begin
                    r_neg  <= w_rd_neg;
                    r_mag  <= w_rd_neg ? 32'd0 - i_rd_data : i_rd_data;
                    r_pidx <= '0;
                    r_dcur <= '0;
                    r_ndig <= '0;
                    r_didx <= '0;
                end
                S_CONV: begin
                    if (w_ge) begin
                        r_mag  <= r_mag - POW10[r_pidx];
                        r_dcur <= r_dcur + 4'd1;
                    end else begin
                        if (r_dcur != 4'd0 || r_ndig != 4'd0 || w_last_pow) r_ndig <= r_ndig + 4'd1;
                        r_dcur <= '0;
                        if (!w_last_pow) r_pidx <= r_pidx + 4'd1;
                    end
                end
                S_SEND_DIG: if (w_tx_start) r_didx <= r_didx + 4'd1;
                S_SEND_SEP: if (w_tx_start) begin
                    r_c       <= r_c + 3'd1;
                    r_rd_addr <= r_rd_addr + 8'd1;
                end
                S_SEND_LF: if (w_tx_start) begin
                    r_c <= '0;
                    if (!w_last_row) begin
                        r_r       <= r_r + 3'd1;
                        r_rd_addr <= r_rd_addr + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the digit buffer is always written before it is read, so it has no reset.
    always_ff @(posedge clk) begin
        if (r_state == S_CONV && !w_ge && (r_dcur != 4'd0 || r_ndig != 4'd0 || w_last_pow))
            r_digits[r_ndig] <= r_dcur;
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_byte_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_start(w_tx_start),
        .tx_data (w_tx_data),
        .tx_busy (w_tx_busy),
        .tx_pin  (uart_tx_pin)
    );

    assign o_rd_addr = r_rd_addr;
    assign o_busy    = !(r_state inside {S_IDLE, S_ERR, S_DONE});
    assign o_done    = (r_state == S_DONE) || (r_state == S_ERR);
    assign o_err     = (r_state == S_ERR);

endmodule

// File: tb/tb_matrix_uart_tx_formatter.sv
// Directed bench for matrix_uart_tx_formatter: decodes the serial line and
// compares the byte stream, handshake pulses and read addresses to hand-made values.
module tb_matrix_uart_tx_formatter;

    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0, start_u = 1'b0;
    logic [7:0]  i_base_addr = '0;
    logic [2:0]  i_m = '0, i_n = '0;
    logic [7:0]  o_rd_addr, rd_addr_u;
    logic [31:0] rd_data = '0, rd_data_u = '0;
    logic        o_busy, o_done, o_err, uart_tx_pin;
    logic        busy_u, done_u, err_u, uart_tx_pin_u;

    logic [31:0] mem [256];
    logic [7:0]  rx_q0[$], rx_q1[$], exp_q[$], addr_q[$];
    logic [7:0]  last_addr = '0;
    int          n_checks = 0, n_fail = 0, rst_events = 0, done_cnt0 = 0;

    always #5 clk = ~clk;

    matrix_uart_tx_formatter #(.CLK_FREQ(1000), .BAUD(100), .MAX_DIM(5), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr), .i_m(i_m), .i_n(i_n),
        .o_rd_addr(o_rd_addr), .i_rd_data(rd_data), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .uart_tx_pin(uart_tx_pin));

    matrix_uart_tx_formatter #(.CLK_FREQ(1000), .BAUD(100), .MAX_DIM(5), .SIGNED_EN(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .i_start(start_u), .i_base_addr(i_base_addr), .i_m(i_m), .i_n(i_n),
        .o_rd_addr(rd_addr_u), .i_rd_data(rd_data_u), .o_busy(busy_u), .o_done(done_u), .o_err(err_u),
        .uart_tx_pin(uart_tx_pin_u));

    always @(posedge clk) begin
        rd_data   <= mem[o_rd_addr];
        rd_data_u <= mem[rd_addr_u];
    end

    always @(negedge clk) begin
        if (o_done) done_cnt0++;
        if (rst_n && o_rd_addr !== last_addr) begin
            addr_q.push_back(o_rd_addr);
            last_addr = o_rd_addr;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic get_pin(input bit which);
        return which ? uart_tx_pin_u : uart_tx_pin;
    endfunction

    // Line decoder: samples mid-bit; frames cut by a reset are discarded.
    task automatic uart_mon(input bit which);
        logic [7:0] b;
        int ev;
        forever begin
            @(negedge clk);
            if (rst_n && get_pin(which) == 1'b0) begin
                ev = rst_events;
                repeat (CPB/2 - 1) @(negedge clk);
                if (ev == rst_events) check("mon_start", get_pin(which), 1'b0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = get_pin(which);
                end
                repeat (CPB) @(negedge clk);
                if (ev == rst_events) begin
                    check("mon_stop", get_pin(which), 1'b1);
                    if (which) rx_q1.push_back(b);
                    else       rx_q0.push_back(b);
                end
            end
        end
    endtask

    initial uart_mon(1'b0);
    initial uart_mon(1'b1);

    task automatic push_line(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic pulse_start(input logic [7:0] base, input logic [2:0] m, input logic [2:0] n, input bit which);
        i_base_addr = base;
        i_m = m;
        i_n = n;
        if (which) start_u = 1'b1;
        else       i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        start_u = 1'b0;
    endtask

    task automatic wait_done(input bit which, input int budget, input string tag);
        int k = 0;
        while (!(which ? done_u : o_done) && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_timeout"}, k >= budget, 1'b0);
    endtask

    task automatic check_stream(input string tag, input bit which);
        int n = which ? rx_q1.size() : rx_q0.size();
        check({tag, "_len"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check($sformatf("%s_b%0d", tag, i), which ? rx_q1[i] : rx_q0[i], exp_q[i]);
    endtask

    task automatic check_idle_line(input string tag, input int cycles);
        int lows = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (uart_tx_pin !== 1'b1) lows++;
        end
        check(tag, lows, 0);
    endtask

    task automatic err_case(input string tag, input logic [2:0] m, input logic [2:0] n);
        int d0 = done_cnt0;
        pulse_start(8'h40, m, n, 1'b0);
        check({tag, "_done"}, o_done, 1'b1);
        check({tag, "_err"}, o_err, 1'b1);
        @(negedge clk);
        check({tag, "_done_low"}, o_done, 1'b0);
        check_idle_line({tag, "_line"}, 20);
        check({tag, "_addr"}, o_rd_addr, 8'h00);
        check({tag, "_done_cnt"}, done_cnt0 - d0, 1);
    endtask

    task automatic run_2x2(input string tag);
        exp_q.delete();
        push_line("1 2");
        push_line("3 4");
        rx_q0.delete();
        pulse_start(8'h10, 3'd2, 3'd2, 1'b0);
        wait_done(1'b0, 5000, tag);
        repeat (10) @(negedge clk);
        check_stream(tag, 1'b0);
        check({tag, "_busy_after"}, o_busy, 1'b0);
    endtask

    initial begin
        int d0, k, lows;
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        mem[8'h10] = 32'd1;
        mem[8'h11] = 32'd2;
        mem[8'h12] = 32'd3;
        mem[8'h13] = 32'd4;
        mem[8'h20] = 32'd0;
        mem[8'h21] = 32'hFFFF_FFFF;
        mem[8'h22] = 32'h8000_0000;
        mem[8'hFE] = 32'd5;
        mem[8'hFF] = 32'd6;
        mem[8'h00] = 32'd7;

        repeat (3) @(negedge clk);
        check("rst_pin", uart_tx_pin, 1'b1);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        check("rst_err", o_err, 1'b0);
        check("rst_addr", o_rd_addr, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        err_case("err_m0", 3'd0, 3'd3);
        err_case("err_m6", 3'd6, 3'd1);

        // 2x2 job with start-bit width measured on the first frame.
        exp_q.delete();
        push_line("1 2");
        push_line("3 4");
        rx_q0.delete();
        addr_q.delete();
        d0 = done_cnt0;
        pulse_start(8'h10, 3'd2, 3'd2, 1'b0);
        check("job_busy", o_busy, 1'b1);
        k = 0;
        while (uart_tx_pin !== 1'b0 && k < 200) begin @(negedge clk); k++; end
        check("startbit_seen", k < 200, 1'b1);
        k = 0;
        while (uart_tx_pin === 1'b0 && k < 50) begin @(negedge clk); k++; end
        check("startbit_width", k, CPB);
        wait_done(1'b0, 5000, "job2x2");
        repeat (10) @(negedge clk);
        check_stream("job2x2", 1'b0);
        check("job2x2_done_cnt", done_cnt0 - d0, 1);
        check("job2x2_busy_after", o_busy, 1'b0);
        check("job2x2_addr_n", addr_q.size(), 4);
        check_idle_line("job2x2_line_after", 30);

        // Signed edge values.
        exp_q.delete();
        push_line("0 -1 -2147483648");
        rx_q0.delete();
        pulse_start(8'h20, 3'd1, 3'd3, 1'b0);
        wait_done(1'b0, 6000, "signed");
        repeat (10) @(negedge clk);
        check_stream("signed", 1'b0);

        // Unsigned instance prints the all-ones word as a positive value.
        exp_q.delete();
        push_line("4294967295");
        rx_q1.delete();
        pulse_start(8'h21, 3'd1, 3'd1, 1'b1);
        wait_done(1'b1, 4000, "unsigned");
        repeat (10) @(negedge clk);
        check_stream("unsigned", 1'b1);

        // Address wrap, with a second start mid-job that must be ignored.
        exp_q.delete();
        push_line("5 6 7");
        rx_q0.delete();
        addr_q.delete();
        d0 = done_cnt0;
        pulse_start(8'hFE, 3'd1, 3'd3, 1'b0);
        repeat (150) @(negedge clk);
        pulse_start(8'h10, 3'd1, 3'd1, 1'b0);
        wait_done(1'b0, 5000, "wrap");
        repeat (20) @(negedge clk);
        check_stream("wrap", 1'b0);
        check("wrap_done_cnt", done_cnt0 - d0, 1);
        check("wrap_addr_n", addr_q.size(), 3);
        if (addr_q.size() == 3) begin
            check("wrap_addr0", addr_q[0], 8'hFE);
            check("wrap_addr1", addr_q[1], 8'hFF);
            check("wrap_addr2", addr_q[2], 8'h00);
        end

        // Reset during a data bit of the second byte.
        rx_q0.delete();
        pulse_start(8'h10, 3'd2, 3'd2, 1'b0);
        k = 0;
        while (rx_q0.size() < 1 && k < 1000) begin @(negedge clk); k++; end
        check("rst_mid_byte1", k < 1000, 1'b1);
        k = 0;
        while (uart_tx_pin !== 1'b0 && k < 300) begin @(negedge clk); k++; end
        check("rst_mid_byte2_start", k < 300, 1'b1);
        repeat (25) @(negedge clk);
        #3;
        rst_events++;
        rst_n = 1'b0;
        #1;
        check("rst_mid_pin", uart_tx_pin, 1'b1);
        check("rst_mid_busy", o_busy, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        repeat (150) begin
            @(negedge clk);
            if (uart_tx_pin !== 1'b1) lows++;
        end
        check("rst_mid_line_idle", lows, 0);
        run_2x2("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
